// File: rtl/h14tx_pkg.sv
// Shared types and colour constants for the HDMI 1.4 TX test-pattern source.
package h14tx_pkg;

    typedef logic [7:0] video_t;
    typedef video_t [2:0] rgb_t;   // [2]=R, [1]=G, [0]=B

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        CHECKER = 2'd1,
        RAMP    = 2'd2,
        BOX     = 2'd3
    } patgen_mode_e;

    localparam rgb_t BAR_LUT [8] = '{
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'h00FF00,   // green
        24'hFF00FF,   // magenta
        24'hFF0000,   // red
        24'h0000FF,   // blue
        24'h000000    // black
    };

    localparam rgb_t BOX_COLOR = 24'hFFFF00;
    localparam rgb_t BOX_BG    = 24'h000040;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t RGB_BLACK = 24'h000000;

endpackage

// File: rtl/h14tx_patgen_box.sv
// Bouncing-box state: position and velocity advance once per frame end,
// reflecting off the active-area edges; flags pixels that fall inside the box.
module h14tx_patgen_box
    import h14tx_pkg::*;
#(
    parameter int BitWidth     = 12,
    parameter int BitHeight    = 11,
    parameter int ActiveWidth  = 1280,
    parameter int ActiveHeight = 720,
    parameter int BoxSize      = 64,
    parameter int BoxStep      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fe,
    input  logic [BitWidth-1:0]  x,
    input  logic [BitHeight-1:0] y,
    output logic                 in_box
);

    localparam logic signed [BitWidth:0]  XMAX   = (BitWidth+1)'(ActiveWidth - BoxSize);
    localparam logic signed [BitHeight:0] YMAX   = (BitHeight+1)'(ActiveHeight - BoxSize);
    localparam logic signed [BitWidth:0]  STEP_X = (BitWidth+1)'(BoxStep);
    localparam logic signed [BitHeight:0] STEP_Y = (BitHeight+1)'(BoxStep);
    localparam logic [BitWidth:0]         SIZE_X = (BitWidth+1)'(BoxSize);
    localparam logic [BitHeight:0]        SIZE_Y = (BitHeight+1)'(BoxSize);

    logic [BitWidth-1:0]         box_x;
    logic [BitHeight-1:0]        box_y;
    logic signed [BitWidth:0]    dx;
    logic signed [BitHeight:0]   dy;
    logic signed [BitWidth:0]    nx;
    logic signed [BitHeight:0]   ny;

    // One extra bit so a step past zero shows up as negative rather than wrapping.
    assign nx = $signed({1'b0, box_x}) + dx;
    assign ny = $signed({1'b0, box_y}) + dy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= '0;
            box_y <= '0;
            dx    <= STEP_X;
            dy    <= STEP_Y;
        end else if (fe) begin
            if (nx > XMAX) begin
                box_x <= XMAX[BitWidth-1:0];
                dx    <= -dx;
            end else if (nx[BitWidth]) begin
                box_x <= '0;
                dx    <= -dx;
            end else begin
                box_x <= nx[BitWidth-1:0];
            end

            if (ny > YMAX) begin
                box_y <= YMAX[BitHeight-1:0];
                dy    <= -dy;
            end else if (ny[BitHeight]) begin
                box_y <= '0;
                dy    <= -dy;
            end else begin
                box_y <= ny[BitHeight-1:0];
            end
        end
    end

    assign in_box = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < ({1'b0, box_x} + SIZE_X)) &&
                    ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < ({1'b0, box_y} + SIZE_Y));

endmodule

// File: rtl/h14tx_patgen.sv
// Runtime-selectable test-pattern source for the HDMI 1.4 TX DVO, 1-cycle latency.
// Optional white frame border on active edge pixels with H14TX_PATGEN_BORDER_EN.
module h14tx_patgen
    import h14tx_pkg::*;
#(
    parameter int BitWidth     = 12,
    parameter int BitHeight    = 11,
    parameter int ActiveWidth  = 1280,
    parameter int ActiveHeight = 720,
    parameter int BoxSize      = 64,
    parameter int BoxStep      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [BitWidth-1:0]  x,
    input  logic [BitHeight-1:0] y,
    output rgb_t                 video,
    output logic [7:0]           frame_cnt
);

    if (ActiveWidth < BoxSize) begin : g_chk_w
        $error("h14tx_patgen: ActiveWidth must be >= BoxSize");
    end
    if (ActiveHeight < BoxSize) begin : g_chk_h
        $error("h14tx_patgen: ActiveHeight must be >= BoxSize");
    end
    if (ActiveWidth % 8 != 0) begin : g_chk_bars
        $error("h14tx_patgen: ActiveWidth must be a multiple of 8");
    end

    patgen_mode_e mode_q;
    logic         fe;
    logic         active;
    logic         in_box;
    logic [2:0]   bar_k;
    rgb_t         pix;

    assign fe = (x == BitWidth'(ActiveWidth - 1)) && (y == BitHeight'(ActiveHeight - 1));
    assign active = ({1'b0, x} < (BitWidth+1)'(ActiveWidth)) &&
                    ({1'b0, y} < (BitHeight+1)'(ActiveHeight));

    h14tx_patgen_box #(
        .BitWidth     (BitWidth),
        .BitHeight    (BitHeight),
        .ActiveWidth  (ActiveWidth),
        .ActiveHeight (ActiveHeight),
        .BoxSize      (BoxSize),
        .BoxStep      (BoxStep)
    ) u_box (
        .clk    (clk),
        .rst_n  (rst_n),
        .fe     (fe),
        .x      (x),
        .y      (y),
        .in_box (in_box)
    );

    // Bar index counts constant boundaries passed; the loop unrolls into seven comparators.
    always_comb begin
        bar_k = '0;
        for (int i = 1; i < 8; i++) begin
            if ({1'b0, x} >= (BitWidth+1)'(i * ActiveWidth / 8)) begin
                bar_k = bar_k + 3'd1;
            end
        end
    end

    always_comb begin
        pix = RGB_BLACK;
        case (mode_q)
            BARS:    pix = BAR_LUT[bar_k];
            CHECKER: pix = (x[5] ^ y[5]) ? RGB_WHITE : RGB_BLACK;
            RAMP:    pix = {x[7:0], y[7:0], frame_cnt};
            BOX:     pix = in_box ? BOX_COLOR : BOX_BG;
            default: pix = RGB_BLACK;
        endcase
`ifdef H14TX_PATGEN_BORDER_EN
        if (x == '0 || x == BitWidth'(ActiveWidth - 1) ||
            y == '0 || y == BitHeight'(ActiveHeight - 1)) begin
            pix = RGB_WHITE;
        end
`endif
        if (!active) begin
            pix = RGB_BLACK;
        end
    end

    // The fe pixel renders from the old state because all state moves on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video     <= RGB_BLACK;
            frame_cnt <= '0;
            mode_q    <= BARS;
        end else begin
            video <= pix;
            if (fe) begin
                mode_q    <= patgen_mode_e'(mode);
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_h14tx_patgen.sv
// Directed bench for h14tx_patgen: bars, checker, ramp, box bounce, reset and border.
module tb_h14tx_patgen;
    import h14tx_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [11:0] x     = 12'd0;
    logic [10:0] y     = 11'd0;
    rgb_t        video;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    localparam rgb_t W  = 24'hFFFFFF;
    localparam rgb_t YL = 24'hFFFF00;
    localparam rgb_t CY = 24'h00FFFF;
    localparam rgb_t GR = 24'h00FF00;
    localparam rgb_t MG = 24'hFF00FF;
    localparam rgb_t RD = 24'hFF0000;
    localparam rgb_t BL = 24'h0000FF;
    localparam rgb_t K  = 24'h000000;
    localparam rgb_t BG = 24'h000040;

`ifdef H14TX_PATGEN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    h14tx_patgen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .x         (x),
        .y         (y),
        .video     (video),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic rgb_t bexp(input int px, input int py, input rgb_t p);
        if (BORDER && (px == 0 || px == 1279 || py == 0 || py == 719)) return W;
        return p;
    endfunction

    // Present one coordinate, then sample its registered pixel on the following negedge.
    task automatic drive(input int px, input int py);
        @(negedge clk);
        x = 12'(px);
        y = 11'(py);
        @(negedge clk);
        x = 12'd1300;
        y = 11'd0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        x = 12'd1279;
        y = 11'd719;
        @(negedge clk);
        x = 12'd1300;
        y = 11'd0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int   vx [13] = '{0, 160, 159, 319, 320, 480, 640, 800, 960, 1119, 1120, 1280, 5};
        int   vy [13] = '{0, 0,   1,   1,   1,   1,   1,   1,   1,   1,    1,    1,    720};
        rgb_t ve [13] = '{W, YL,  W,   YL,  CY,  GR,  MG,  RD,  BL,  BL,   K,    K,    K};
        rgb_t e;
        rst_n = 1'b0;
        mode  = 2'd0;
        #12;
        checks++;
        if (video !== K) begin
            errors++;
            $display("FAIL reset_video: got %h want %h", video, K);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vx[i], vy[i]);
            e = bexp(vx[i], vy[i], ve[i]);
            checks++;
            if (video !== e) begin
                errors++;
                $display("FAIL bars(%0d,%0d): got %h want %h", vx[i], vy[i], video, e);
            end
        end
    endtask

    task automatic test_ramp();
        int   vx [4] = '{5, 200, 255, 256};
        int   vy [4] = '{3, 300, 255, 1};
        rgb_t ve [4] = '{24'h050301, 24'hC82C01, 24'hFFFF01, 24'h000101};
        mode = 2'd2;
        @(negedge clk);
        x = 12'd1279;
        y = 11'd719;
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ramp_pre_fe_cnt: got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        x = 12'd1300;
        y = 11'd0;
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ramp_post_fe_cnt: got %0d want 1", frame_cnt);
        end
        checks++;
        if (video !== bexp(1279, 719, K)) begin
            errors++;
            $display("FAIL fe_pixel_old_state: got %h want %h", video, bexp(1279, 719, K));
        end
        for (int i = 0; i < 4; i++) begin
            drive(vx[i], vy[i]);
            checks++;
            if (video !== ve[i]) begin
                errors++;
                $display("FAIL ramp(%0d,%0d): got %h want %h", vx[i], vy[i], video, ve[i]);
            end
        end
    endtask

    task automatic test_mode_hold();
        int   vx [5] = '{32, 32, 64, 64, 31};
        int   vy [5] = '{0,  32, 32, 64, 31};
        rgb_t ve [5] = '{W,  K,  W,  K,  K};
        rgb_t e;
        mode = 2'd0;
        end_frame();
        drive(160, 1);
        checks++;
        if (video !== YL) begin
            errors++;
            $display("FAIL hold_bars_before: got %h want %h", video, YL);
        end
        mode = 2'd1;
        drive(32, 32);
        checks++;
        if (video !== W) begin
            errors++;
            $display("FAIL hold_bars_midframe: got %h want %h", video, W);
        end
        end_frame();
        checks++;
        if (frame_cnt !== 8'd3) begin
            errors++;
            $display("FAIL hold_frame_cnt: got %0d want 3", frame_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            drive(vx[i], vy[i]);
            e = bexp(vx[i], vy[i], ve[i]);
            checks++;
            if (video !== e) begin
                errors++;
                $display("FAIL checker(%0d,%0d): got %h want %h", vx[i], vy[i], video, e);
            end
        end
    endtask

    task automatic test_box_bounce();
        int   ax [8]  = '{2, 65, 1,  2,  66, 2,  1280, 100};
        int   ay [8]  = '{2, 65, 2,  1,  2,  66, 100,  720};
        rgb_t ae [8]  = '{YL, YL, BG, BG, BG, BG, K,   K};
        int   bx [5]  = '{1216, 1279, 1215, 1216, 1216};
        int   by [5]  = '{96,   159,  100,  95,   160};
        rgb_t be [5]  = '{YL,   YL,   BG,   BG,   BG};
        int   cx [4]  = '{1214, 1277, 1278, 1213};
        int   cy [4]  = '{94,   157,  94,   94};
        rgb_t ce [4]  = '{YL,   YL,   BG,   BG};
        rgb_t e;
        rst_pulse();
        mode = 2'd3;
        end_frame();
        for (int i = 0; i < 8; i++) begin
            drive(ax[i], ay[i]);
            e = bexp(ax[i], ay[i], ae[i]);
            checks++;
            if (video !== e) begin
                errors++;
                $display("FAIL box_start(%0d,%0d): got %h want %h", ax[i], ay[i], video, e);
            end
        end
        for (int n = 2; n <= 609; n++) begin
            end_frame();
            if (n == 255) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL cnt_255: got %0d want 255", frame_cnt);
                end
            end
            if (n == 256) begin
                checks++;
                if (frame_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL cnt_wrap: got %0d want 0", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'd97) begin
            errors++;
            $display("FAIL cnt_609: got %0d want 97", frame_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            drive(bx[i], by[i]);
            e = bexp(bx[i], by[i], be[i]);
            checks++;
            if (video !== e) begin
                errors++;
                $display("FAIL box_right(%0d,%0d): got %h want %h", bx[i], by[i], video, e);
            end
        end
        end_frame();
        for (int i = 0; i < 4; i++) begin
            drive(cx[i], cy[i]);
            e = bexp(cx[i], cy[i], ce[i]);
            checks++;
            if (video !== e) begin
                errors++;
                $display("FAIL box_back(%0d,%0d): got %h want %h", cx[i], cy[i], video, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        rst_pulse();
        mode = 2'd3;
        for (int n = 0; n < 10; n++) end_frame();
        @(negedge clk);
        x = 12'd700;
        y = 11'd400;
        @(negedge clk);
        checks++;
        if (video !== BG) begin
            errors++;
            $display("FAIL pre_reset_bg: got %h want %h", video, BG);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (video !== K) begin
            errors++;
            $display("FAIL async_reset_video: got %h want %h", video, K);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_cnt: got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(700, 400);
        checks++;
        if (video !== MG) begin
            errors++;
            $display("FAIL post_reset_bars: got %h want %h", video, MG);
        end
        end_frame();
        drive(2, 2);
        checks++;
        if (video !== YL) begin
            errors++;
            $display("FAIL post_reset_box_in: got %h want %h", video, YL);
        end
        drive(1, 1);
        checks++;
        if (video !== BG) begin
            errors++;
            $display("FAIL post_reset_box_out: got %h want %h", video, BG);
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_border();
        int   vx [4] = '{0,   1279, 640, 640};
        int   vy [4] = '{100, 300,  0,   300};
        rgb_t e;
        for (int i = 0; i < 4; i++) begin
            drive(vx[i], vy[i]);
            e = bexp(vx[i], vy[i], BG);
            checks++;
            if (video !== e) begin
                errors++;
                $display("FAIL border(%0d,%0d): got %h want %h", vx[i], vy[i], video, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_mode_hold();
        test_box_bounce();
        test_reset_midframe();
        test_border();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/h14tx_patgen.md
Name: h14tx_patgen

Overview:
- Upstream video source for the HDMI 1.4 TX DVO stage.
- Consumes the pixel coordinates (x, y) that the DVO produces and returns one video_t per TMDS channel, registered.
- Serves as a bring-up and test source selectable at runtime: colour bars, checkerboard, gradient ramp, and a bouncing box.
- Pattern changes take effect only at frame boundaries, so the output never tears.

Parameters:
- BitWidth, 12, width of x.
- BitHeight, 11, width of y.
- ActiveWidth, 1280, active pixels per line; x in [0, ActiveWidth) is active.
- ActiveHeight, 720, active lines; y in [0, ActiveHeight) is active.
- BoxSize, 64, edge length of the moving box in pixels.
- BoxStep, 2, box displacement per frame on each axis, in pixels.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  requested pattern: 0 bars, 1 checker, 2 ramp, 3 box.
- x  in  BitWidth  current pixel column, from the DVO.
- y  in  BitHeight  current pixel row, from the DVO.
- video  out  3 x video_t  [2]=R, [1]=G, [0]=B.
- frame_cnt  out  8  completed-frame counter.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: video=0, frame_cnt=0, mode_q=0, box_x=0, box_y=0, dx=+BoxStep, dy=+BoxStep.
- Latency: video is exactly 1 clk after the (x, y) it corresponds to. The DVO is built for this 1-cycle source latency.
- Inactive pixels: if x>=ActiveWidth or y>=ActiveHeight, video=0 in every mode.
- Frame-end event (fe): the cycle where x==ActiveWidth-1 and y==ActiveHeight-1. On fe:
  - mode_q <= mode;
  - frame_cnt <= frame_cnt+1, wrapping 255 -> 0;
  - box position and velocity update (see box mode).
  - The fe pixel itself still renders with the pre-fe state. The new state applies from the next frame's first pixel.
- mode changes between fe events are ignored. The first frame after reset renders bars.
- Bars (mode_q=0):
  - 8 equal bars, bar index k = number of boundaries b_i = i*ActiveWidth/8 (i=1..7) with x >= b_i.
  - Boundaries are elaboration-time constants; no divider in the datapath.
  - Colours for k=0..7 (R,G,B): white FF,FF,FF; yellow FF,FF,00; cyan 00,FF,FF; green 00,FF,00; magenta FF,00,FF; red FF,00,00; blue 00,00,FF; black 00,00,00.
- Checker (mode_q=1): 32x32 squares. If x[5]^y[5] is 1, video = FF,FF,FF; otherwise 00,00,00.
- Ramp (mode_q=2): R=x[7:0], G=y[7:0], B=frame_cnt.
- Box (mode_q=3):
  - Background 00,00,40 (dark blue). Inside box_x<=x<box_x+BoxSize and box_y<=y<box_y+BoxSize: FF,FF,00.
  - On fe, nx = box_x+dx, computed in signed arithmetic of width BitWidth+1.
  - If nx > ActiveWidth-BoxSize: box_x <= ActiveWidth-BoxSize and dx <= -dx.
  - Else if nx < 0: box_x <= 0 and dx <= -dx.
  - Else: box_x <= nx.
  - Y axis is identical, using ActiveHeight and BitHeight+1.
  - Box state updates on every fe regardless of mode, so the motion is continuous when switching into box mode.
- Reset asserted mid-frame: all state returns to reset values immediately. The output pattern restarts as bars from the next rendered pixel.
- Elaboration assertions: ActiveWidth>=BoxSize, ActiveHeight>=BoxSize, ActiveWidth%8==0.

Optional Feature:
- Macro: H14TX_PATGEN_BORDER_EN.
- Defined: any active pixel with x==0, x==ActiveWidth-1, y==0, or y==ActiveHeight-1 outputs FF,FF,FF in all modes. This overrides the pattern with the same 1-cycle latency.
- Undefined: no border logic is generated. Output is the pure pattern.

Decomposition:
- Goes in h14tx_pkg:
  - patgen_mode_e (BARS, CHECKER, RAMP, BOX);
  - the bar colour LUT as a constant array of 8 video_t triples;
  - BOX_COLOR and BOX_BG constants.
- One sub-module: h14tx_patgen_box, which owns box_x/box_y/dx/dy, takes fe, and outputs the in_box flag. The parent holds the mode mux and output register.

Test Plan:
- Reset, then drive x=0,y=0 followed by x=160,y=0 -> after reset, video=0. One clk after each coordinate, video = FF,FF,FF then FF,FF,00.
- Scan a full 1280x720 frame with mode=2 held -> frame_cnt goes 0 -> 1 one clk after fe. Frame 1 pixel (x=5,y=3) -> video = 05,03,01.
- mode toggles 0 -> 1 mid-frame -> bars continue until fe. Next frame pixel (x=32,y=0) = FF,FF,FF and (x=32,y=32) = 00,00,00.
- mode=3, run 609 frames -> box_x reaches 1216 with dx=-2. The next frame gives box_x=1214. Pixels (1216,y) inside the box are FF,FF,00 when box_x=1216.
- Assert rst_n low at x=700,y=400 of frame 10 in box mode -> frame_cnt=0, box at (0,0), video=0 asynchronously. After release, the pattern renders as bars.
- With H14TX_PATGEN_BORDER_EN, mode=3, pixel (x=0,y=100) -> FF,FF,FF. Without the macro -> 00,00,40.
